// File: rtl/fp8_pkg.sv
// Shared types and constants for the BF16 -> FP8 (OCP E4M3) conversion path.
package fp8_pkg;

  localparam int BF16_BIAS = 127;
  localparam int FP8_BIAS  = 7;
  localparam int BIAS_DIFF = BF16_BIAS - FP8_BIAS;  // 120

  localparam logic [6:0] FP8_MAX_FIN = 7'h7E;  // 448, largest finite E4M3 magnitude
  localparam logic [6:0] FP8_NAN     = 7'h7F;  // the only NaN encoding in E4M3

  // Input classification decided in stage 1 and acted on in stage 2.
  typedef enum logic [2:0] {
    ZERO,
    SUBN,
    NORM,
    INF,
    NAN
  } lane_class_e;

  // Per-lane state carried from stage 1 to stage 2.
  typedef struct packed {
    logic        s;        // sign
    lane_class_e cls;      // input class
    logic [6:0]  code;     // truncated E4M3 magnitude (exp:mant)
    logic        g;        // guard bit
    logic        st;       // sticky bit
    logic        ovf_pre;  // exponent already too large before rounding
  } s1_lane_t;

  // Magnitude produced for an overflowing lane under the selected policy.
  function automatic logic [6:0] ovf_code(input logic sat);
    return sat ? FP8_MAX_FIN : FP8_NAN;
  endfunction

endpackage

// File: rtl/bf16_fp8_lane.sv
// One conversion lane, purely combinational. The stage-1 half classifies the
// BF16 input and aligns it to E4M3; the stage-2 half rounds, detects overflow
// and packs. The top registers the struct between the two halves.
module bf16_fp8_lane
  import fp8_pkg::*;
(
  input  logic [15:0] bf16_i,
  output s1_lane_t    s1_o,
  input  s1_lane_t    s2_i,
  input  logic        rne_i,
  input  logic        sat_i,
  output logic [7:0]  fp8_o,
  output logic        ovf_o
);

  logic [7:0] exp_b;
  logic [6:0] man_b;
  logic [7:0] e_fp8;   // rebiased exponent for the normal range
  logic [7:0] sh;      // right shift for the subnormal range (125 - E)
  logic [7:0] sig;     // significand with hidden one
  logic       up;
  logic [7:0] sum;     // rounded magnitude, bit 7 is carry-out

  assign exp_b = bf16_i[14:7];
  assign man_b = bf16_i[6:0];
  assign e_fp8 = exp_b - 8'(BIAS_DIFF);
  assign sh    = 8'(BIAS_DIFF + 5) - exp_b;
  assign sig   = {1'b1, man_b};

  // Stage-1 half: classify the input and produce truncated code, guard, sticky.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    s1_o     = '0;
    s1_o.s   = bf16_i[15];
    s1_o.cls = ZERO;
    if (exp_b == 8'hFF) begin
      s1_o.cls = (man_b != 7'd0) ? NAN : INF;
    end else if (exp_b == 8'h00) begin
      s1_o.cls = ZERO;
    end else if (exp_b > 8'(BIAS_DIFF)) begin
      s1_o.cls     = NORM;
      s1_o.code    = {e_fp8[3:0], man_b[6:4]};
      s1_o.g       = man_b[3];
      s1_o.st      = |man_b[2:0];
      s1_o.ovf_pre = (e_fp8 > 8'd15);
    end else begin
      // E in 1..120 gives sh in 5..124; only sh 5..8 leaves anything to round.
      s1_o.cls = SUBN;
      unique case (sh)
        8'd5: begin
          s1_o.code = 7'(sig[7:5]);
          s1_o.g    = sig[4];
          s1_o.st   = |sig[3:0];
        end
        8'd6: begin
          s1_o.code = 7'(sig[7:6]);
          s1_o.g    = sig[5];
          s1_o.st   = |sig[4:0];
        end
        8'd7: begin
          s1_o.code = 7'(sig[7]);
          s1_o.g    = sig[6];
          s1_o.st   = |sig[5:0];
        end
        8'd8: begin
          s1_o.code = 7'd0;
          s1_o.g    = sig[7];
          s1_o.st   = |sig[6:0];
        end
        default: begin
          // Too small to reach half the smallest subnormal: signed zero.
          s1_o.code = 7'd0;
          s1_o.g    = 1'b0;
          s1_o.st   = 1'b0;
        end
      endcase
    end
  end

  assign up  = rne_i & s2_i.g & (s2_i.st | s2_i.code[0]);
  assign sum = {1'b0, s2_i.code} + 8'(up);

  // Stage-2 half: round to nearest-even if enabled, then apply overflow policy.
  always_comb begin
    ovf_o = 1'b0;
    fp8_o = {s2_i.s, sum[6:0]};
    unique case (s2_i.cls)
      NAN:  fp8_o = {s2_i.s, FP8_NAN};
      INF: begin
        ovf_o = 1'b1;
        fp8_o = {s2_i.s, ovf_code(sat_i)};
      end
      ZERO: fp8_o = {s2_i.s, 7'h00};
      default: begin
        // A carry from 0x07 into 0x08 promotes subnormal to normal for free;
        // a result of 0x7F or a carry out of 7 bits is past the finite range.
        if (s2_i.ovf_pre || (sum == 8'h7F) || sum[7]) begin
          ovf_o = 1'b1;
          fp8_o = {s2_i.s, ovf_code(sat_i)};
        end
      end
    endcase
  end

endmodule

// File: rtl/bf16_to_fp8_pipe.sv
// Multi-lane, two-stage BF16 -> FP8 E4M3 converter with valid/ready on both
// sides and a saturating count of overflowed lanes. Stage 1 holds the
// classified/aligned lanes plus the cfg bits of that beat; stage 2 holds the
// packed result and the per-lane overflow flags.
module bf16_to_fp8_pipe
  import fp8_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_rne,
  input  logic                 cfg_sat,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*LANES-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  input  logic                 clr_count,
  output logic [CNT_W-1:0]     sat_count
);

  localparam int POP_W = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + POP_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Combinational lane outputs.
  s1_lane_t [LANES-1:0]  lane_s1;
  logic [8*LANES-1:0]    lane_fp8;
  logic [LANES-1:0]      lane_ovf;

  // Pipeline state.
  logic                  s1_v_q, s1_v_d;
  s1_lane_t [LANES-1:0]  s1_lane_q, s1_lane_d;
  logic                  s1_rne_q, s1_rne_d;
  logic                  s1_sat_q, s1_sat_d;
  logic                  s2_v_q, s2_v_d;
  logic [8*LANES-1:0]    s2_data_q, s2_data_d;
  logic [LANES-1:0]      s2_ovf_q, s2_ovf_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  load1, load2;
  logic [POP_W-1:0]      ovf_pop;
  logic [SUM_W-1:0]      cnt_sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bf16_fp8_lane u_lane (
      .bf16_i (in_data[16*i +: 16]),
      .s1_o   (lane_s1[i]),
      .s2_i   (s1_lane_q[i]),
      .rne_i  (s1_rne_q),
      .sat_i  (s1_sat_q),
      .fp8_o  (lane_fp8[8*i +: 8]),
      .ovf_o  (lane_ovf[i])
    );
  end

  // A stage loads when it is empty or its contents move on this cycle.
  assign load2     = !s2_v_q || out_ready;
  assign load1     = !s1_v_q || load2;
  assign in_ready  = load1;
  assign out_valid = s2_v_q;
  assign out_data  = s2_data_q;
  assign sat_count = cnt_q;

  // Next-state of both pipeline stages.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_lane_d = s1_lane_q;
    s1_rne_d  = s1_rne_q;
    s1_sat_d  = s1_sat_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_ovf_d  = s2_ovf_q;
    if (load1) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_lane_d = lane_s1;
        s1_rne_d  = cfg_rne;
        s1_sat_d  = cfg_sat;
      end
    end
    if (load2) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_data_d = lane_fp8;
        s2_ovf_d  = lane_ovf;
      end
    end
  end

  // Number of overflowed lanes in the beat currently held by stage 2.
  always_comb begin
    ovf_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      // NOTE: blocking assignment is right here: the loop accumulates within
      // one evaluation of combinational logic.
      ovf_pop = ovf_pop + POP_W'(s2_ovf_q[i]);
    end
  end

  assign cnt_sum = SUM_W'(cnt_q) + SUM_W'(ovf_pop);

  // Saturating overflow counter; clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (s2_v_q && out_ready) begin
      cnt_d = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, not just the valids, because
      // out_data must read zero out of reset and the cost is a few dozen flops.
      s1_v_q    <= 1'b0;
      s1_lane_q <= '0;
      s1_rne_q  <= 1'b0;
      s1_sat_q  <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_ovf_q  <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_v_q    <= s1_v_d;
      s1_lane_q <= s1_lane_d;
      s1_rne_q  <= s1_rne_d;
      s1_sat_q  <= s1_sat_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_ovf_q  <= s2_ovf_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
